// File: rtl/execute_alu_odffs_pipe.sv
`default_nettype none
// ============================================================================
// Module   : execute_alu_odffs_pipe
// Brief    : Elastic ALU writeback output stage. DEPTH register stages with a
//            valid/ready handshake, bubble collapsing, a global flush and
//            saturating commit-delay ageing while a packet is in flight.
//            Optional macro ODFFS_FID_FLUSH_EN adds a per-fetch-id flush.
// Revision : 1.0 - initial release
// ============================================================================
module execute_alu_odffs_pipe #(
  parameter int DEPTH    = 1,
  parameter int DATA_W   = 32,
  parameter int ROB_W    = 4,
  parameter int FID_W    = 8,
  parameter int CMTD_W   = 4,
  parameter int CMTD_AGE = 1
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [ROB_W-1:0]  i_dst_rob,
  input  logic [FID_W-1:0]  i_fid,
  input  logic [DATA_W-1:0] i_result,
  input  logic [CMTD_W-1:0] i_cmtdelay,
`ifdef ODFFS_FID_FLUSH_EN
  input  logic              i_flush_fid_valid,
  input  logic [FID_W-1:0]  i_flush_fid,
`endif
  input  logic              i_flush,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [ROB_W-1:0]  o_dst_rob,
  output logic [FID_W-1:0]  o_fid,
  output logic [DATA_W-1:0] o_result,
  output logic [CMTD_W-1:0] o_cmtdelay
);

  localparam logic [CMTD_W-1:0] CMTD_ONE = {{(CMTD_W-1){1'b0}}, 1'b1};

  // Stage state: valid bits are reset, payload registers are not.
  logic [DEPTH-1:0]  v;
  logic [DEPTH-1:0]  adv;
  logic [DEPTH-1:0]  kill;
  logic              kill_in;
  logic [ROB_W-1:0]  rob_q  [DEPTH];
  logic [FID_W-1:0]  fid_q  [DEPTH];
  logic [DATA_W-1:0] res_q  [DEPTH];
  logic [CMTD_W-1:0] cmtd_q [DEPTH];

  // One clock of ageing: saturating decrement, or identity when ageing is off.
  function automatic logic [CMTD_W-1:0] age(input logic [CMTD_W-1:0] c);
    if (CMTD_AGE == 0 || c == '0) return c;
    return c - CMTD_ONE;
  endfunction

  // Stage k may load when some stage from k to the output is empty or the
  // output is accepted: closed form of the bubble-collapsing ready chain.
  for (genvar k = 0; k < DEPTH; k++) begin : g_adv
    assign adv[k] = i_ready | ~(&v[DEPTH-1:k]);
  end

`ifdef ODFFS_FID_FLUSH_EN
  // Selective kill of in-flight and incoming packets carrying the flushed fid.
  for (genvar k = 0; k < DEPTH; k++) begin : g_fid_kill
    assign kill[k] = i_flush_fid_valid & (fid_q[k] == i_flush_fid);
  end
  assign kill_in = i_flush_fid_valid & (i_fid == i_flush_fid);
`else
  assign kill    = '0;
  assign kill_in = 1'b0;
`endif

  // Valid bits: clear on reset/flush, otherwise load from upstream or hold.
  // A killed stage simply loses its valid bit and becomes a bubble.
  always_ff @(posedge clk) begin
    if (!resetn || i_flush) begin
      v <= '0;
    end else begin
      v[0] <= adv[0] ? (i_valid & ~kill_in) : (v[0] & ~kill[0]);
      for (int k = 1; k < DEPTH; k++) begin
        v[k] <= adv[k] ? (v[k-1] & ~kill[k-1]) : (v[k] & ~kill[k]);
      end
    end
  end

  // Payload: load on advance, otherwise hold. Commit delay ages on every
  // clock in flight, both when moving and when stalled; the value entering
  // stage 0 is taken unmodified.
  always_ff @(posedge clk) begin
    if (adv[0]) begin
      rob_q[0]  <= i_dst_rob;
      fid_q[0]  <= i_fid;
      res_q[0]  <= i_result;
      cmtd_q[0] <= i_cmtdelay;
    end else begin
      cmtd_q[0] <= age(cmtd_q[0]);
    end
    for (int k = 1; k < DEPTH; k++) begin
      if (adv[k]) begin
        rob_q[k]  <= rob_q[k-1];
        fid_q[k]  <= fid_q[k-1];
        res_q[k]  <= res_q[k-1];
        cmtd_q[k] <= age(cmtd_q[k-1]);
      end else begin
        cmtd_q[k] <= age(cmtd_q[k]);
      end
    end
  end

  // A flush empties every stage, so the head can always accept in that cycle.
  assign o_ready    = adv[0] | i_flush;
  assign o_valid    = v[DEPTH-1];
  assign o_dst_rob  = rob_q[DEPTH-1];
  assign o_fid      = fid_q[DEPTH-1];
  assign o_result   = res_q[DEPTH-1];
  assign o_cmtdelay = cmtd_q[DEPTH-1];

endmodule
`default_nettype wire

// File: tb/tb_execute_alu_odffs_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_execute_alu_odffs_pipe
// Brief    : Two pipes (DEPTH=2 and DEPTH=3) fed from per-pipe elastic
//            sources, checked every cycle against a packet/position model.
//            Build with ODFFS_FID_FLUSH_EN to include the fid-flush scenario.
// Revision : 1.0 - initial release
// ============================================================================
module tb_execute_alu_odffs_pipe;

  typedef struct {
    logic [3:0]  rob;
    logic [7:0]  fid;
    logic [31:0] res;
    logic [3:0]  cmtd;
    int          pos;
    int          acc_cyc;
  } pkt_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rstn = 1'b0;
  logic        rdy = 1'b0;
  logic        flush = 1'b0;
  logic        ffv = 1'b0;
  logic [7:0]  ffid = 8'h00;

  logic        in_valid [2];
  logic [3:0]  in_rob   [2];
  logic [7:0]  in_fid   [2];
  logic [31:0] in_res   [2];
  logic [3:0]  in_cmtd  [2];
  logic        out_ready[2];
  logic        out_valid[2];
  logic [3:0]  out_rob  [2];
  logic [7:0]  out_fid  [2];
  logic [31:0] out_res  [2];
  logic [3:0]  out_cmtd [2];

  execute_alu_odffs_pipe #(.DEPTH(2)) dut2 (
    .clk(clk), .resetn(rstn), .i_valid(in_valid[0]), .o_ready(out_ready[0]),
    .i_dst_rob(in_rob[0]), .i_fid(in_fid[0]), .i_result(in_res[0]),
    .i_cmtdelay(in_cmtd[0]),
`ifdef ODFFS_FID_FLUSH_EN
    .i_flush_fid_valid(ffv), .i_flush_fid(ffid),
`endif
    .i_flush(flush), .o_valid(out_valid[0]), .i_ready(rdy),
    .o_dst_rob(out_rob[0]), .o_fid(out_fid[0]), .o_result(out_res[0]),
    .o_cmtdelay(out_cmtd[0])
  );

  execute_alu_odffs_pipe #(.DEPTH(3)) dut3 (
    .clk(clk), .resetn(rstn), .i_valid(in_valid[1]), .o_ready(out_ready[1]),
    .i_dst_rob(in_rob[1]), .i_fid(in_fid[1]), .i_result(in_res[1]),
    .i_cmtdelay(in_cmtd[1]),
`ifdef ODFFS_FID_FLUSH_EN
    .i_flush_fid_valid(ffv), .i_flush_fid(ffid),
`endif
    .i_flush(flush), .o_valid(out_valid[1]), .i_ready(rdy),
    .o_dst_rob(out_rob[1]), .o_fid(out_fid[1]), .o_result(out_res[1]),
    .o_cmtdelay(out_cmtd[1])
  );

  // Model state: in-flight packets oldest first, upstream sources, delivery log.
  pkt_t mq   [2][4];
  int   mn   [2];
  pkt_t src  [2][32];
  int   sh   [2];
  int   st   [2];
  pkt_t lg   [2][32];
  int   lcyc [2][32];
  int   ln   [2];
  int   cycle = 0;
  int   total = 0;
  int   bad = 0;

  function automatic int dep(input int d);
    return (d == 0) ? 2 : 3;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cycle);
    end
  endtask

  // A packet moves one stage forward if the slot ahead is free after the
  // packets ahead of it have moved; the oldest leaves when at the end and
  // accepted. The head can accept if stage 0 ends up free.
  function automatic bit model_ready(input int d);
    int bound;
    int np;
    if (flush) return 1'b1;
    bound = dep(d) - 1;
    for (int i = 0; i < mn[d]; i++) begin
      if (i == 0 && mq[d][0].pos == dep(d) - 1 && rdy) continue;
      np = (mq[d][i].pos + 1 < bound) ? mq[d][i].pos + 1 : bound;
      bound = np - 1;
    end
    return bound >= 0;
  endfunction

  task automatic model_step(input int d, input bit acc);
    pkt_t nq [4];
    pkt_t p;
    int   nn;
    int   bound;
    int   np;
    nn = 0;
    if (!rstn || flush) begin
      mn[d] = 0;
      return;
    end
    bound = dep(d) - 1;
    for (int i = 0; i < mn[d]; i++) begin
      p = mq[d][i];
      if (i == 0 && p.pos == dep(d) - 1 && rdy) begin
        lg[d][ln[d]] = p;
        lcyc[d][ln[d]] = cycle;
        ln[d]++;
        continue;
      end
      np = (p.pos + 1 < bound) ? p.pos + 1 : bound;
      p.pos = np;
      bound = np - 1;
      p.cmtd = (p.cmtd == 4'd0) ? 4'd0 : p.cmtd - 4'd1;
      if (!(ffv && p.fid == ffid)) begin
        nq[nn] = p;
        nn++;
      end
    end
    if (acc) begin
      p = src[d][sh[d]];
      p.pos = 0;
      p.acc_cyc = cycle;
      if (!(ffv && p.fid == ffid)) begin
        nq[nn] = p;
        nn++;
      end
    end
    for (int i = 0; i < nn; i++) mq[d][i] = nq[i];
    mn[d] = nn;
  endtask

  task automatic push(input logic [31:0] res, input logic [7:0] fid, input logic [3:0] cmtd);
    pkt_t p;
    p.rob = res[3:0];
    p.fid = fid;
    p.res = res;
    p.cmtd = cmtd;
    p.pos = 0;
    p.acc_cyc = 0;
    for (int d = 0; d < 2; d++) begin
      src[d][st[d]] = p;
      st[d]++;
    end
  endtask

  // One clock: drive at the falling edge, compare every output against the
  // model, then advance the model at the rising edge.
  task automatic cyc(input bit r, input bit f, input bit rs, input bit fv, input logic [7:0] fi);
    bit acc [2];
    bit expv;
    @(negedge clk);
    rdy = r;
    flush = f;
    rstn = rs;
    ffv = fv;
    ffid = fi;
    for (int d = 0; d < 2; d++) begin
      in_valid[d] = (sh[d] != st[d]);
      in_rob[d]   = in_valid[d] ? src[d][sh[d]].rob  : 4'h0;
      in_fid[d]   = in_valid[d] ? src[d][sh[d]].fid  : 8'h00;
      in_res[d]   = in_valid[d] ? src[d][sh[d]].res  : 32'h0;
      in_cmtd[d]  = in_valid[d] ? src[d][sh[d]].cmtd : 4'h0;
    end
    #1;
    for (int d = 0; d < 2; d++) begin
      expv = (mn[d] > 0) && (mq[d][0].pos == dep(d) - 1);
      chk($sformatf("o_valid[d%0d]", dep(d)), {63'd0, out_valid[d]}, {63'd0, expv});
      chk($sformatf("o_ready[d%0d]", dep(d)), {63'd0, out_ready[d]}, {63'd0, model_ready(d)});
      if (expv) begin
        chk($sformatf("o_dst_rob[d%0d]", dep(d)), {60'd0, out_rob[d]}, {60'd0, mq[d][0].rob});
        chk($sformatf("o_fid[d%0d]", dep(d)), {56'd0, out_fid[d]}, {56'd0, mq[d][0].fid});
        chk($sformatf("o_result[d%0d]", dep(d)), {32'd0, out_res[d]}, {32'd0, mq[d][0].res});
        chk($sformatf("o_cmtdelay[d%0d]", dep(d)), {60'd0, out_cmtd[d]}, {60'd0, mq[d][0].cmtd});
      end
      acc[d] = in_valid[d] && model_ready(d) && rstn;
    end
    @(posedge clk);
    cycle++;
    for (int d = 0; d < 2; d++) begin
      model_step(d, acc[d]);
      if (acc[d]) sh[d]++;
    end
  endtask

  task automatic run(input int n, input bit r);
    for (int i = 0; i < n; i++) cyc(r, 1'b0, 1'b1, 1'b0, 8'h00);
  endtask

  task automatic do_reset();
    for (int d = 0; d < 2; d++) begin
      sh[d] = 0;
      st[d] = 0;
      ln[d] = 0;
    end
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      in_valid[d] = 1'b0; in_rob[d] = '0; in_fid[d] = '0; in_res[d] = '0; in_cmtd[d] = '0;
      mn[d] = 0; sh[d] = 0; st[d] = 0; ln[d] = 0;
    end
    @(posedge clk);
    @(posedge clk);
    #2;

    // Reset state.
    do_reset();
    #2;
    chk("reset o_valid d2", {63'd0, out_valid[0]}, 64'd0);
    chk("reset o_ready d2", {63'd0, out_ready[0]}, 64'd1);
    chk("reset o_valid d3", {63'd0, out_valid[1]}, 64'd0);
    chk("reset o_ready d3", {63'd0, out_ready[1]}, 64'd1);

    // Streaming, no stall.
    push(32'h11, 8'h01, 4'd3);
    push(32'h22, 8'h02, 4'd3);
    push(32'h33, 8'h03, 4'd3);
    run(7, 1'b1);
    chk("stream count d2", ln[0], 3);
    chk("stream res0 d2", lg[0][0].res, 32'h11);
    chk("stream res1 d2", lg[0][1].res, 32'h22);
    chk("stream res2 d2", lg[0][2].res, 32'h33);
    chk("stream cmtd d2", lg[0][2].cmtd, 4'd2);
    chk("stream latency d2", lcyc[0][0] - lg[0][0].acc_cyc, 2);
    chk("stream gapless d2", lcyc[0][2] - lcyc[0][0], 2);
    chk("stream count d3", ln[1], 3);
    chk("stream cmtd d3", lg[1][0].cmtd, 4'd1);
    chk("stream latency d3", lcyc[1][0] - lg[1][0].acc_cyc, 3);

    // Backpressure and saturating age.
    do_reset();
    push(32'h44, 8'h04, 4'd3);
    push(32'h55, 8'h05, 4'd3);
    push(32'h66, 8'h06, 4'd3);
    run(8, 1'b0);
    #2;
    chk("bp held d2", mn[0], 2);
    chk("bp upstream left d2", st[0] - sh[0], 1);
    chk("bp o_ready d2", {63'd0, out_ready[0]}, 64'd0);
    chk("bp o_cmtdelay d2", {60'd0, out_cmtd[0]}, 64'd0);
    chk("bp held d3", mn[1], 3);
    run(7, 1'b1);
    chk("bp count d2", ln[0], 3);
    chk("bp res0 d2", lg[0][0].res, 32'h44);
    chk("bp res2 d2", lg[0][2].res, 32'h66);
    chk("bp count d3", ln[1], 3);

    // Bubble collapse.
    do_reset();
    push(32'h77, 8'h07, 4'd5);
    run(2, 1'b0);
    push(32'h88, 8'h08, 4'd5);
    run(1, 1'b0);
    #2;
    chk("bubble held d3", mn[1], 2);
    chk("bubble o_ready d3", {63'd0, out_ready[1]}, 64'd1);
    run(1, 1'b0);
    chk("bubble middle d3", mq[1][1].pos, 1);
    push(32'h99, 8'h09, 4'd5);
    run(1, 1'b0);
    #2;
    chk("bubble full d3", mn[1], 3);
    chk("bubble o_ready full d3", {63'd0, out_ready[1]}, 64'd0);
    push(32'hAA, 8'h0A, 4'd5);
    run(2, 1'b0);
    run(8, 1'b1);
    chk("bubble count d3", ln[1], 4);
    chk("bubble order d3", lg[1][1].res, 32'h88);
    chk("bubble last d3", lg[1][3].res, 32'hAA);

    // Global flush with accept and output both active.
    do_reset();
    push(32'hB1, 8'h11, 4'd2);
    push(32'hB2, 8'h12, 4'd2);
    run(2, 1'b1);
    push(32'hB3, 8'h13, 4'd2);
    cyc(1'b1, 1'b1, 1'b1, 1'b0, 8'h00);
    #2;
    chk("flush o_valid d2", {63'd0, out_valid[0]}, 64'd0);
    chk("flush o_ready d2", {63'd0, out_ready[0]}, 64'd1);
    run(5, 1'b1);
    chk("flush delivered d2", ln[0], 0);
    chk("flush delivered d3", ln[1], 0);

    // Reset with a full, stalled pipe.
    do_reset();
    for (int i = 0; i < 4; i++) push(32'hC0 + i, 8'h20 + i[7:0], 4'd4);
    run(5, 1'b0);
    #2;
    chk("pre-reset o_valid d2", {63'd0, out_valid[0]}, 64'd1);
    do_reset();
    #2;
    chk("post-reset o_valid d2", {63'd0, out_valid[0]}, 64'd0);
    chk("post-reset o_valid d3", {63'd0, out_valid[1]}, 64'd0);
    push(32'h5A, 8'h30, 4'd4);
    run(5, 1'b1);
    chk("post-reset count d2", ln[0], 1);
    chk("post-reset latency d2", lcyc[0][0] - lg[0][0].acc_cyc, 2);
    chk("post-reset latency d3", lcyc[1][0] - lg[1][0].acc_cyc, 3);

`ifdef ODFFS_FID_FLUSH_EN
    // Selective flush by fetch id.
    do_reset();
    push(32'hA1, 8'h05, 4'd6);
    push(32'hA2, 8'h07, 4'd6);
    push(32'hA3, 8'h05, 4'd6);
    run(4, 1'b0);
    cyc(1'b0, 1'b0, 1'b1, 1'b1, 8'h05);
    run(7, 1'b1);
    chk("fid flush count d3", ln[1], 1);
    chk("fid flush res d3", lg[1][0].res, 32'hA2);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Absolute bound on run time.
  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

endmodule
`default_nettype wire

// File: doc/execute_alu_odffs_pipe.md
Name: execute_alu_odffs_pipe

Overview:
Parametrised, elastic successor of the ALU output DFF stage. Carries ALU writeback packets (dst ROB index, fetch id, result, commit delay) through DEPTH register stages with a valid/ready handshake, bubble collapsing and a global flush. Commit delay ages while a packet is in flight. Sits between the ALU datapath and the writeback/commit arbiter, which may stall it.

Parameters:
DEPTH, 1, number of register stages (1..4).
DATA_W, 32, result width.
ROB_W, 4, ROB index width.
FID_W, 8, fetch id width.
CMTD_W, 4, commit delay width.
CMTD_AGE, 1, 1 = decrement commit delay each cycle in flight; 0 = pass through unchanged.

Ports:
clk  in  1  clock
resetn  in  1  synchronous active-low reset
i_valid  in  1  upstream packet valid
o_ready  out  1  stage 0 can accept this cycle
i_dst_rob  in  ROB_W  destination ROB entry
i_fid  in  FID_W  fetch id
i_result  in  DATA_W  ALU result
i_cmtdelay  in  CMTD_W  commit delay
i_flush  in  1  kill all in-flight packets
o_valid  out  1  last-stage packet valid
i_ready  in  1  downstream accepts
o_dst_rob  out  ROB_W  last-stage ROB entry
o_fid  out  FID_W  last-stage fetch id
o_result  out  DATA_W  last-stage result
o_cmtdelay  out  CMTD_W  last-stage (aged) commit delay

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-low on resetn, sampled at the rising edge of clk.
- Reset: all stage valid bits = 0, so o_valid = 0 and o_ready = 1 in the cycle after reset. Data registers are not reset; their outputs are don't-care while the stage is invalid. Reset mid-operation drops all packets, with no partial output.
- Stage k (0..DEPTH-1) holds v[k] and its payload. Stage DEPTH-1 drives the outputs.
- Advance rules:
  - adv[DEPTH-1] = ~v[DEPTH-1] | i_ready.
  - adv[k] = ~v[k] | (adv[k+1] & ~... ) — in full: stage k may load when it is empty or when its contents move to k+1. Stage k+1 loads from k when v[k] & adv[k+1].
  - This is a bubble-collapsing chain: an empty stage never blocks an upstream packet.
- o_ready = adv[0]. The ready chain is combinational from i_ready. Accept happens when i_valid & o_ready.
- Transfer out happens when o_valid & i_ready.
- Latency: DEPTH cycles from accept to o_valid with no stalls. Throughput is 1 packet/cycle.
- Ordering is strictly FIFO. Capacity is DEPTH packets.
- Full state: all v = 1 and i_ready = 0 gives o_ready = 0. Payloads hold and o_* are stable while stalled.
- Commit delay ageing (CMTD_AGE = 1): every clock an entry is valid and not flushed, its cmtdelay becomes max(cmtdelay-1, 0). This applies whether the entry moves or stalls. Decrement saturates at 0 and never wraps. The value loaded into stage 0 is i_cmtdelay unmodified.
- With no stall, o_cmtdelay = max(i_cmtdelay-(DEPTH-1), 0).
- Flush: when i_flush = 1 at a clock edge:
  - all v are cleared;
  - an input accepted that same cycle is dropped;
  - the packet presented on o_* that same cycle is considered not transferred, even if i_ready = 1.
  - o_ready is 1 in the flush cycle.
- Simultaneous flush and resetn = 0: reset dominates, with the same result.
- Flush with an empty pipe: no effect.

Optional Feature:
ODFFS_FID_FLUSH_EN:
- Defined: adds ports i_flush_fid_valid (in, 1) and i_flush_fid (in, FID_W).
  - When i_flush_fid_valid = 1, every valid stage whose fid == i_flush_fid is invalidated at the clock edge, and an incoming matching packet is dropped. Non-matching packets continue.
  - The stage that was killed becomes a bubble and collapses under the normal advance rules.
  - i_flush still kills everything and takes priority.
- Undefined: these ports are absent and only the global i_flush exists.

Test Plan:
- Streaming, DEPTH=2, i_ready=1: send 3 packets on consecutive cycles with results 0x11, 0x22, 0x33 and cmtdelay 3 -> o_valid from cycle 2 for 3 cycles, results 0x11, 0x22, 0x33 in order, o_cmtdelay=2 each.
- Backpressure, DEPTH=2: i_ready=0, push 3 packets -> 2 accepted, o_ready=0 on the third, which is held upstream. Stall 5 cycles with cmtdelay 3 -> o_cmtdelay saturates at 0. Release i_ready -> all 3 delivered in order, no loss or duplication.
- Bubble collapse, DEPTH=3: one packet with a gap, then the last stage stalled -> the second packet fills the empty middle stage, and o_ready stays 1 until 3 packets are held.
- Flush, DEPTH=2: 2 packets in flight, i_flush=1 together with i_valid=1 and i_ready=1 -> next cycle o_valid=0, no packet ever delivered, o_ready=1.
- Reset mid-stream: resetn=0 for 1 cycle with a full, stalled pipe -> o_valid=0 the next cycle. A post-reset packet emerges after DEPTH cycles.
- ODFFS_FID_FLUSH_EN, DEPTH=3: in flight fid 0x05, 0x07, 0x05; flush fid 0x05 -> only the 0x07 packet is delivered.
